// File: rtl/ps2_key_if.sv
// Bundle between the PS/2 receive FIFO, the key decoder and the game logic.
// The master side is the decoder: it pops the FIFO and drives key events.
interface ps2_key_if;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_break;
  logic       key_valid;
  logic [3:0] held;
  logic       left_pulse;
  logic       right_pulse;
  logic       down_pulse;
  logic       rot_pulse;

  modport master (
    input  fifo_empty, fifo_data,
    output fifo_rd, key_code, key_ext, key_break, key_valid, held,
           left_pulse, right_pulse, down_pulse, rot_pulse
  );

  modport slave (
    output fifo_empty, fifo_data,
    input  fifo_rd, key_code, key_ext, key_break, key_valid, held,
           left_pulse, right_pulse, down_pulse, rot_pulse
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// Pops PS/2 scancodes from a FWFT FIFO, parses E0/F0/E1 prefixes into key events,
// and tracks held game keys with auto-repeating move pulses and a one-shot rotate.
module ps2_key_decoder #(
  parameter logic [7:0] KEY_LEFT    = 8'h34,
  parameter logic [7:0] KEY_RIGHT   = 8'h36,
  parameter logic [7:0] KEY_DOWN    = 8'h32,
  parameter logic [7:0] KEY_ROT     = 8'h35,
  parameter int         REP_DELAY   = 6250000,
  parameter int         REP_RATE    = 1250000,
  parameter int         PFX_TIMEOUT = 2500000
) (
  input  logic     clk,
  input  logic     rst,
  ps2_key_if.master bus
);

  localparam int CNT_MAX = (REP_DELAY > REP_RATE) ? REP_DELAY : REP_RATE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TMO_W   = $clog2(PFX_TIMEOUT + 1);

  typedef enum logic [2:0] {ST_IDLE, ST_E0, ST_F0, ST_E0F0, ST_SKIP} state_t;

  state_t           state_q, state_d;
  logic [2:0]       skip_q, skip_d;
  logic [TMO_W-1:0] tmo_q;
  logic             rd_q;
  logic             consume;
  logic             ev_fire, ev_ext, ev_brk;
  logic             key_make, key_brk;
  logic [3:0]       hit;

  logic [7:0]       code_q;
  logic             ext_q, brk_q, valid_q;
  logic [3:0]       held_q, pulse_q;
  logic [CNT_W-1:0] rep_q [3];

  // Pop only on a non-empty head and never in back-to-back cycles.
  assign consume     = rst & ~bus.fifo_empty & ~rd_q;
  assign bus.fifo_rd = consume;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_d = state_q;
    skip_d  = skip_q;
    ev_fire = 1'b0;
    ev_ext  = 1'b0;
    ev_brk  = 1'b0;
    if (consume) begin
      case (state_q)
        ST_IDLE: begin
          case (bus.fifo_data)
            8'hE0: state_d = ST_E0;
            8'hF0: state_d = ST_F0;
            8'hE1: begin
              state_d = ST_SKIP;
              skip_d  = 3'd7;
            end
            8'hFA, 8'hFE, 8'hAA, 8'hEE, 8'h00, 8'hFF: ;
            default: ev_fire = 1'b1;
          endcase
        end
        ST_E0: begin
          if (bus.fifo_data == 8'hF0) state_d = ST_E0F0;
          else if (bus.fifo_data != 8'hE0) begin
            ev_fire = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_F0: begin
          ev_fire = 1'b1;
          ev_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_E0F0: begin
          ev_fire = 1'b1;
          ev_ext  = 1'b1;
          ev_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_SKIP: begin
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = ST_IDLE;
          end else begin
            skip_d = skip_q - 3'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE && tmo_q == TMO_W'(PFX_TIMEOUT - 1)) begin
      // Abandon a prefix whose follow-up byte never arrived.
      state_d = ST_IDLE;
      skip_d  = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop updates together at the edge.
    if (!rst) begin
      state_q <= ST_IDLE;
      skip_q  <= 3'd0;
      tmo_q   <= '0;
      rd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      tmo_q   <= (consume || state_q == ST_IDLE) ? '0 : tmo_q + 1'b1;
      rd_q    <= consume;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= 1'b0;
      code_q  <= 8'h00;
      ext_q   <= 1'b0;
      brk_q   <= 1'b0;
    end else begin
      valid_q <= ev_fire;
      if (ev_fire) begin
        code_q <= bus.fifo_data;
        ext_q  <= ev_ext;
        brk_q  <= ev_brk;
      end
    end
  end

  // Game keys are plain (non-E0) codes; bit order {rot,down,right,left}.
  assign hit = {bus.fifo_data == KEY_ROT,   bus.fifo_data == KEY_DOWN,
                bus.fifo_data == KEY_RIGHT, bus.fifo_data == KEY_LEFT};
  assign key_make = ev_fire & ~ev_ext & ~ev_brk;
  assign key_brk  = ev_fire & ~ev_ext &  ev_brk;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      held_q  <= '0;
      pulse_q <= '0;
      // NOTE: the repeat counters are a few flops, not a RAM, so they are reset like any register.
      for (int i = 0; i < 3; i++) rep_q[i] <= '0;
    end else begin
      pulse_q <= '0;
      for (int i = 0; i < 3; i++) begin
        if (key_make && hit[i] && !held_q[i]) begin
          held_q[i]  <= 1'b1;
          pulse_q[i] <= 1'b1;
          rep_q[i]   <= CNT_W'(REP_DELAY);
        end else if (key_brk && hit[i]) begin
          held_q[i] <= 1'b0;
          rep_q[i]  <= '0;
        end else if (held_q[i]) begin
          if (rep_q[i] == CNT_W'(1)) begin
            pulse_q[i] <= 1'b1;
            rep_q[i]   <= CNT_W'(REP_RATE);
          end else begin
            rep_q[i] <= rep_q[i] - 1'b1;
          end
        end
      end
      if (key_make && hit[3] && !held_q[3]) begin
        held_q[3]  <= 1'b1;
        pulse_q[3] <= 1'b1;
      end else if (key_brk && hit[3]) begin
        held_q[3] <= 1'b0;
      end
    end
  end

  assign bus.key_code    = code_q;
  assign bus.key_ext     = ext_q;
  assign bus.key_break   = brk_q;
  assign bus.key_valid   = valid_q;
  assign bus.held        = held_q;
  assign bus.left_pulse  = pulse_q[0];
  assign bus.right_pulse = pulse_q[1];
  assign bus.down_pulse  = pulse_q[2];
  assign bus.rot_pulse   = pulse_q[3];

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a FIFO model feeds scancodes, expected
// events and pulses are queued at stimulus time and matched by a negedge monitor.
module tb_ps2_key_decoder;

  typedef struct {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [3:0] held;
  } ev_t;

  typedef struct {
    int which;
    int ofs;
  } pl_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ps2_key_if bus ();

  ps2_key_decoder #(
    .REP_DELAY  (20),
    .REP_RATE   (5),
    .PFX_TIMEOUT(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [7:0] fifo_q [$];
  ev_t        exp_ev [$];
  pl_t        exp_pl [$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         last_ev = 0;
  logic       prev_rd = 1'b0;
  ev_t        mon_e;
  pl_t        mon_p;
  logic [3:0] mon_pv;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: observed but not expected", name);
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
  endtask

  task automatic exp_event(input logic [7:0] code, input logic ext, input logic brk,
                           input logic [3:0] held);
    ev_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.held = held;
    exp_ev.push_back(e);
  endtask

  task automatic exp_pulse(input int which, input int ofs);
    pl_t p;
    p.which = which; p.ofs = ofs;
    exp_pl.push_back(p);
  endtask

  task automatic wait_drain();
    bit done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      if (fifo_q.size() == 0) done = 1'b1;
      else @(negedge clk);
    end
    if (!done) fail_now("fifo_drain_timeout");
  endtask

  // FWFT FIFO model: pop on the sampled strobe, present the new head shortly after the edge.
  always @(posedge clk) begin
    if (bus.fifo_rd && fifo_q.size() != 0) void'(fifo_q.pop_front());
    #1;
    bus.fifo_empty = (fifo_q.size() == 0);
    bus.fifo_data  = (fifo_q.size() != 0) ? fifo_q[0] : 8'h00;
  end

  // Monitor: pops expected events/pulses whenever the DUT presents one.
  always @(negedge clk) begin
    cyc++;
    if (bus.fifo_rd) begin
      check("rd_back_to_back", {31'd0, prev_rd}, 0);
      check("rd_while_empty", {31'd0, bus.fifo_empty}, 0);
    end
    prev_rd = bus.fifo_rd;
    if (bus.key_valid) begin
      last_ev = cyc;
      if (exp_ev.size() == 0) fail_now("unexpected_event");
      else begin
        mon_e = exp_ev.pop_front();
        check("ev_code", {24'd0, bus.key_code}, {24'd0, mon_e.code});
        check("ev_ext", {31'd0, bus.key_ext}, {31'd0, mon_e.ext});
        check("ev_break", {31'd0, bus.key_break}, {31'd0, mon_e.brk});
        check("ev_held", {28'd0, bus.held}, {28'd0, mon_e.held});
      end
    end
    mon_pv = {bus.rot_pulse, bus.down_pulse, bus.right_pulse, bus.left_pulse};
    for (int k = 0; k < 4; k++) begin
      if (mon_pv[k]) begin
        if (exp_pl.size() == 0) fail_now("unexpected_pulse");
        else begin
          mon_p = exp_pl.pop_front();
          check("pulse_which", k, mon_p.which);
          check("pulse_offset", cyc - last_ev, mon_p.ofs);
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_valid", {31'd0, bus.key_valid}, 0);
    check("rst_code", {24'd0, bus.key_code}, 0);
    check("rst_held", {28'd0, bus.held}, 0);
    check("rst_pulses", {28'd0, bus.rot_pulse, bus.down_pulse, bus.right_pulse, bus.left_pulse}, 0);
    check("rst_rd", {31'd0, bus.fifo_rd}, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Left make then break.
    exp_event(8'h34, 1'b0, 1'b0, 4'b0001);
    exp_pulse(0, 0);
    exp_event(8'h34, 1'b0, 1'b1, 4'b0000);
    push(8'h34); push(8'hF0); push(8'h34);
    wait_drain();
    repeat (6) @(negedge clk);
    check("t1_held", {28'd0, bus.held}, 0);

    // Ignored bytes, then an extended key that must not touch held or pulses.
    exp_event(8'h75, 1'b1, 1'b0, 4'b0000);
    exp_event(8'h75, 1'b1, 1'b1, 4'b0000);
    push(8'hFA); push(8'hAA); push(8'hE0); push(8'h75);
    push(8'hE0); push(8'hF0); push(8'h75);
    wait_drain();
    repeat (6) @(negedge clk);
    check("t2_held", {28'd0, bus.held}, 0);

    // Right auto-repeat: pulses at +0, +20, +25, +30, +35, break before +40.
    exp_event(8'h36, 1'b0, 1'b0, 4'b0010);
    exp_pulse(1, 0); exp_pulse(1, 20); exp_pulse(1, 25); exp_pulse(1, 30); exp_pulse(1, 35);
    push(8'h36);
    wait_drain();
    repeat (34) @(negedge clk);
    exp_event(8'h36, 1'b0, 1'b1, 4'b0000);
    push(8'hF0); push(8'h36);
    wait_drain();
    repeat (12) @(negedge clk);
    check("t3_held", {28'd0, bus.held}, 0);

    // Typematic rotate: one pulse only.
    exp_event(8'h35, 1'b0, 1'b0, 4'b1000);
    exp_pulse(3, 0);
    exp_event(8'h35, 1'b0, 1'b0, 4'b1000);
    exp_event(8'h35, 1'b0, 1'b0, 4'b1000);
    exp_event(8'h35, 1'b0, 1'b1, 4'b0000);
    push(8'h35); push(8'h35); push(8'h35); push(8'hF0); push(8'h35);
    wait_drain();
    repeat (6) @(negedge clk);

    // Pause sequence is swallowed; the following down key decodes normally.
    exp_event(8'h32, 1'b0, 1'b0, 4'b0100);
    exp_pulse(2, 0);
    exp_event(8'h32, 1'b0, 1'b1, 4'b0000);
    push(8'hE1); push(8'h14); push(8'h77); push(8'hE1);
    push(8'hF0); push(8'h14); push(8'hF0); push(8'h77);
    push(8'h32); push(8'hF0); push(8'h32);
    wait_drain();
    repeat (6) @(negedge clk);
    check("t5_held", {28'd0, bus.held}, 0);

    // Stale F0 times out, so the later 32 is a make.
    push(8'hF0);
    wait_drain();
    repeat (12) @(negedge clk);
    exp_event(8'h32, 1'b0, 1'b0, 4'b0100);
    exp_pulse(2, 0);
    push(8'h32);
    wait_drain();
    repeat (3) @(negedge clk);
    check("t6_held", {28'd0, bus.held}, 32'h4);
    check("t6_events_done", exp_ev.size(), 0);
    check("t6_pulses_done", exp_pl.size(), 0);

    // Asynchronous reset while a key is held clears everything at once.
    #2 rst = 1'b0;
    #1;
    check("arst_held", {28'd0, bus.held}, 0);
    check("arst_valid", {31'd0, bus.key_valid}, 0);
    check("arst_code", {24'd0, bus.key_code}, 0);
    check("arst_pulses", {28'd0, bus.rot_pulse, bus.down_pulse, bus.right_pulse, bus.left_pulse}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("end_held", {28'd0, bus.held}, 0);
    check("end_events_left", exp_ev.size(), 0);
    check("end_pulses_left", exp_pl.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
